// File: rtl/psram_tx_fifo.sv
// psram_tx_fifo: prefetching transmit FIFO between the RAM read port and the PSRAM transmit engine
module psram_tx_fifo #(
  parameter int DW = 32,
  parameter int DEPTH = 4,
  parameter int LW = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          hclk,
  input  logic          hrst,
  input  logic          start,
  input  logic [LW-1:0] tx_len,
  output logic          ram_rd_req,
  input  logic          ram_rd_ack,
  input  logic [DW-1:0] ram_rdata,
  output logic          tx_vld,
  output logic [DW-1:0] tx_data,
  input  logic          tx_free,
  output logic [AW:0]   level,
  output logic          done,
  output logic          underrun
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  state_t state;
  logic [AW:0] wr_ptr, rd_ptr;
  logic [LW-1:0] fetch_rem, pop_rem;
  logic [DW-1:0] mem [DEPTH];
  logic push, pop;
  assign level = wr_ptr - rd_ptr;
  assign ram_rd_req = (state == RUN) && (fetch_rem != '0) && (level != FULL_LVL);
  assign tx_vld = level != '0;
  assign tx_data = mem[rd_ptr[AW-1:0]];
  assign done = state == DONE;
  assign push = ram_rd_req && ram_rd_ack && !start;
  assign pop = tx_vld && tx_free && !start;
  always_ff @(posedge hclk)
    if (push) mem[wr_ptr[AW-1:0]] <= ram_rdata;
  always_ff @(posedge hclk or posedge hrst)
    if (hrst) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fetch_rem <= '0;
      pop_rem <= '0;
      underrun <= 1'b0;
    end else if (start) begin
      state <= (tx_len != '0) ? RUN : DONE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fetch_rem <= tx_len;
      pop_rem <= tx_len;
      underrun <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        fetch_rem <= fetch_rem - 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        pop_rem <= pop_rem - 1'b1;
      end
      if (tx_free && !tx_vld) underrun <= 1'b1;
      if (state == RUN && push && fetch_rem == LW'(1))
        state <= (pop && pop_rem == LW'(1)) ? DONE : DRAIN;
      else if (state == DRAIN && pop && pop_rem == LW'(1))
        state <= DONE;
    end
endmodule

// File: tb/tb_psram_tx_fifo.sv
// tb_psram_tx_fifo: directed scoreboard bench for psram_tx_fifo
module tb_psram_tx_fifo;
  localparam int DW = 32, DEPTH = 4, LW = 16, AW = 2;
  logic hclk = 0, hrst = 1, start = 0, ram_rd_ack = 0, tx_free = 0;
  logic [LW-1:0] tx_len = '0;
  logic [DW-1:0] ram_rdata = '0;
  logic ram_rd_req, tx_vld, done, underrun;
  logic [DW-1:0] tx_data;
  logic [AW:0] level;
  int checks = 0, errors = 0;
  logic [DW-1:0] q[$];
  int m_fetch = 0, m_pop = 0;
  bit started = 0, m_und = 0;

  psram_tx_fifo #(.DW(DW), .DEPTH(DEPTH), .LW(LW)) dut (
    .hclk(hclk), .hrst(hrst), .start(start), .tx_len(tx_len),
    .ram_rd_req(ram_rd_req), .ram_rd_ack(ram_rd_ack), .ram_rdata(ram_rdata),
    .tx_vld(tx_vld), .tx_data(tx_data), .tx_free(tx_free),
    .level(level), .done(done), .underrun(underrun)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_fetch = 0;
    m_pop = 0;
    started = 0;
    m_und = 0;
  endtask

  // One clock: drive inputs on the falling edge, check outputs against the model, update the model.
  task automatic cyc(input bit a, input bit f, input bit s = 0, input int len = 0);
    logic [DW-1:0] d;
    bit req_e, vld_e;
    d = $urandom;
    @(negedge hclk);
    start = s;
    tx_len = LW'(len);
    ram_rd_ack = a;
    tx_free = f;
    ram_rdata = d;
    #1;
    req_e = started && m_fetch != 0 && q.size() < DEPTH;
    vld_e = q.size() != 0;
    chk("req", ram_rd_req, req_e);
    chk("vld", tx_vld, vld_e);
    chk("level", level, q.size());
    chk("done", done, started && m_pop == 0);
    chk("underrun", underrun, m_und);
    if (s) begin
      q.delete();
      m_fetch = len;
      m_pop = len;
      started = 1;
      m_und = 0;
    end else begin
      if (f && !vld_e) m_und = 1;
      if (vld_e && f) begin
        chk("data", tx_data, q.pop_front());
        m_pop--;
      end
      if (req_e && a) begin
        q.push_back(d);
        m_fetch--;
      end
    end
    @(posedge hclk);
    #1;
    start = 0;
    ram_rd_ack = 0;
    tx_free = 0;
  endtask

  task automatic drain(input int max);
    for (int i = 0; i < max && !done; i++) cyc($urandom_range(0, 1), $urandom_range(0, 1));
    chk("drain_done", done, 1);
  endtask

  initial begin
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    hrst = 0;
    #1;
    chk("rst_req", ram_rd_req, 0);
    chk("rst_vld", tx_vld, 0);
    chk("rst_level", level, 0);
    chk("rst_done", done, 0);
    // 1: three words streamed with ack and free held high
    cyc(0, 0, 1, 3);
    for (int i = 0; i < 5; i++) cyc(1, 1);
    chk("t1_done", done, 1);
    chk("t1_req", ram_rd_req, 0);
    // 2: fill to DEPTH with the transmitter stalled, then one pop
    cyc(0, 0, 1, 10);
    for (int i = 0; i < 6; i++) cyc(1, 0);
    chk("t2_level", level, 4);
    chk("t2_req", ram_rd_req, 0);
    cyc(0, 1);
    chk("t2_level3", level, 3);
    chk("t2_req_again", ram_rd_req, 1);
    for (int i = 0; i < 40 && !done; i++) cyc(1, 1);
    chk("t2_done", done, 1);
    // 3: full with ack+free, simultaneous push/pop, then 16 words through the wrap
    cyc(0, 0, 1, 16);
    for (int i = 0; i < 4; i++) cyc(1, 0);
    chk("t3_full", level, 4);
    cyc(1, 1);
    chk("t3_ack_ignored", level, 3);
    cyc(1, 1);
    chk("t3_push_pop", level, 3);
    drain(400);
    // 4: zero-length transfer
    cyc(0, 0, 1, 0);
    chk("t4_done", done, 1);
    for (int i = 0; i < 3; i++) cyc(1, 0);
    chk("t4_req", ram_rd_req, 0);
    // 5: underrun is sticky until the next start
    cyc(0, 1);
    chk("t5_und", underrun, 1);
    cyc(0, 0);
    chk("t5_und_held", underrun, 1);
    cyc(0, 0, 1, 2);
    chk("t5_und_clr", underrun, 0);
    drain(100);
    // 6: restart mid-transfer with an ack in the same cycle, then async reset
    cyc(0, 0, 1, 8);
    cyc(1, 0);
    cyc(1, 0);
    chk("t6_level2", level, 2);
    cyc(1, 0, 1, 5);
    chk("t6_flushed", level, 0);
    chk("t6_not_done", done, 0);
    cyc(1, 0);
    cyc(1, 1);
    @(negedge hclk);
    #2;
    hrst = 1;
    #1;
    chk("t6_rst_req", ram_rd_req, 0);
    chk("t6_rst_vld", tx_vld, 0);
    chk("t6_rst_level", level, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_und", underrun, 0);
    @(posedge hclk);
    @(negedge hclk);
    hrst = 0;
    model_reset();
    cyc(1, 1);
    cyc(0, 0, 1, 2);
    drain(100);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
